// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a pending (reservation) bit per register.
module regfile_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     any_busy
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;
  // reservation is applied after the write clear so a new producer wins
  always_comb begin
    pending_d = pending_q;
    if (we) pending_d[waddr] = 1'b0;
    if (rsv_en) pending_d[rsv_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= (INIT_MODE == 1) ? DATA_W'(i * 10) : '0;
    end else begin
      pending_q <= pending_d;
      if (we && waddr != '0) mem_q[waddr] <= wdata;
    end
  end
  assign any_busy = |pending_q;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = (BYPASS != 0) && we && (waddr == a) && (a != '0);
    assign rd_data[k*DATA_W +: DATA_W] = (a == '0) ? '0 : hit ? wdata : mem_q[a];
    assign rd_busy[k] = pending_q[a] & ~(hit & ~(rsv_en && rsv_addr == a));
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector check of a bypassing 4-port and a non-bypassing 2-port instance.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst, we, rsv_en;
  logic [4:0]  waddr, rsv_addr;
  logic [31:0] wdata;
  logic [19:0] ra4;
  logic [9:0]  ra2;
  logic [127:0] rd4;
  logic [63:0] rd2;
  logic [3:0]  busy4;
  logic [1:0]  busy2;
  logic        any4, any2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1), .INIT_MODE(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(ra4), .rd_data(rd4), .rd_busy(busy4), .we(we),
    .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any4));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .INIT_MODE(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(ra2), .rd_data(rd2), .rd_busy(busy2), .we(we),
    .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any2));

  typedef struct {
    logic        chk, rst, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rsv;
    logic [4:0]  rsa, a0, a1, a2, a3;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  busy;
    logic        any;
    logic [31:0] n0, n1;
    logic [1:0]  nbusy;
  } vec_t;

  vec_t v[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            chk  rst  we  wa    wd            rsv  rsa   a0    a1    a2    a3    d0            d1            d2            d3            busy     any   n0            n1            nbusy
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd1, 5'd31,5'd5, 32'd0,        32'd10,       32'd310,      32'd50,       4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b1,5'd5, 32'hDEADBEEF,1'b0,5'd0, 5'd5, 5'd5, 5'd0, 5'd1, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0,        32'd10,       4'b0000,1'b0,32'd50 & 32'h0,32'h0,      2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd5, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000,1'b0,32'hDEADBEEF, 32'hDEADBEEF, 2'b00});
    v.push_back('{1'b1,1'b0,1'b1,5'd0, 32'h1234,    1'b1,5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd7, 5'd7, 5'd7, 5'd1, 5'd2, 32'd70,       32'd70,       32'd10,       32'd20,       4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b1,5'd7, 32'h55,      1'b0,5'd0, 5'd7, 5'd7, 5'd7, 5'd3, 32'h55,       32'h55,       32'h55,       32'd30,       4'b0000,1'b1,32'h0,        32'h0,        2'b11});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd7, 5'd7, 5'd7, 5'd7, 32'h55,       32'h55,       32'h55,       32'h55,       4'b0000,1'b0,32'h55,       32'h55,       2'b00});
    v.push_back('{1'b1,1'b0,1'b1,5'd9, 32'hAA,      1'b1,5'd9, 5'd9, 5'd9, 5'd1, 5'd9, 32'hAA,       32'hAA,       32'd10,       32'hAA,       4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd9, 5'd9, 5'd9, 5'd0, 32'hAA,       32'hAA,       32'hAA,       32'h0,        4'b0111,1'b1,32'hAA,       32'hAA,       2'b11});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd9, 5'd9, 5'd9, 5'd9, 5'd0, 32'hAA,       32'hAA,       32'hAA,       32'h0,        4'b0111,1'b1,32'hAA,       32'hAA,       2'b11});
    v.push_back('{1'b1,1'b0,1'b1,5'd9, 32'hBB,      1'b1,5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 32'hBB,       32'hBB,       32'hBB,       32'hBB,       4'b1111,1'b1,32'hAA,       32'hAA,       2'b11});
    v.push_back('{1'b1,1'b0,1'b1,5'd9, 32'hCC,      1'b0,5'd0, 5'd9, 5'd9, 5'd9, 5'd9, 32'hCC,       32'hCC,       32'hCC,       32'hCC,       4'b0000,1'b1,32'hBB,       32'hBB,       2'b11});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd9, 5'd9, 5'd9, 5'd9, 32'hCC,       32'hCC,       32'hCC,       32'hCC,       4'b0000,1'b0,32'hCC,       32'hCC,       2'b00});
    v.push_back('{1'b1,1'b0,1'b1,5'd12,32'h77,      1'b0,5'd0, 5'd12,5'd12,5'd12,5'd12,32'h77,       32'h77,       32'h77,       32'h77,       4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd12,5'd12,5'd3, 5'd4, 32'h77,       32'h77,       32'd30,       32'd40,       4'b0000,1'b0,32'h77,       32'h77,       2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd3, 5'd3, 5'd4, 5'd3, 5'd4, 32'd30,       32'd40,       32'd30,       32'd40,       4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd4, 5'd3, 5'd4, 5'd3, 5'd4, 32'd30,       32'd40,       32'd30,       32'd40,       4'b0101,1'b1,32'h0,        32'h0,        2'b01});
    v.push_back('{1'b0,1'b1,1'b1,5'd3, 32'hFFFF,    1'b1,5'd5, 5'd3, 5'd4, 5'd5, 5'd4, 32'h0,        32'h0,        32'h0,        32'h0,        4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd3, 5'd4, 5'd5, 5'd12,32'd30,       32'd40,       32'd50,       32'd120,      4'b0000,1'b0,32'h0,        32'h0,        2'b00});
    v.push_back('{1'b1,1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 5'd4, 5'd4, 5'd4, 5'd4, 32'd40,       32'd40,       32'd40,       32'd40,       4'b0000,1'b0,32'h0,        32'h0,        2'b00});

    rst = 1'b1; we = 1'b0; rsv_en = 1'b0; waddr = '0; rsv_addr = '0; wdata = '0; ra4 = '0; ra2 = '0;
    repeat (2) @(posedge clk);
    foreach (v[i]) begin
      @(negedge clk);
      rst = v[i].rst; we = v[i].we; waddr = v[i].wa; wdata = v[i].wd;
      rsv_en = v[i].rsv; rsv_addr = v[i].rsa;
      ra4 = {v[i].a3, v[i].a2, v[i].a1, v[i].a0};
      ra2 = {v[i].a1, v[i].a0};
      #2;
      if (v[i].chk) begin
        check($sformatf("v%0d d0", i), rd4[31:0], v[i].d0);
        check($sformatf("v%0d d1", i), rd4[63:32], v[i].d1);
        check($sformatf("v%0d d2", i), rd4[95:64], v[i].d2);
        check($sformatf("v%0d d3", i), rd4[127:96], v[i].d3);
        check($sformatf("v%0d busy", i), {28'h0, busy4}, {28'h0, v[i].busy});
        check($sformatf("v%0d any", i), {31'h0, any4}, {31'h0, v[i].any});
        check($sformatf("v%0d nb_d0", i), rd2[31:0], v[i].n0);
        check($sformatf("v%0d nb_d1", i), rd2[63:32], v[i].n1);
        check($sformatf("v%0d nb_busy", i), {30'h0, busy2}, {30'h0, v[i].nbusy});
        check($sformatf("v%0d nb_any", i), {31'h0, any2}, {31'h0, v[i].any});
      end
    end

    // two outstanding reservations: any_busy must hold until the last producer writes
    @(negedge clk);
    rst = 1'b0; we = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd1; ra4 = {5'd0, 5'd0, 5'd2, 5'd1};
    @(negedge clk);
    rsv_addr = 5'd2;
    @(negedge clk);
    rsv_en = 1'b0; we = 1'b1; waddr = 5'd1; wdata = 32'h11;
    #2;
    check("seq any after r1 write req", {31'h0, any4}, 32'd1);
    check("seq busy r1 bypass, r2 pending", {28'h0, busy4}, 32'h2);
    @(negedge clk);
    waddr = 5'd2; wdata = 32'h22;
    #2;
    check("seq any with r2 pending", {31'h0, any4}, 32'd1);
    check("seq r1 stored", rd4[31:0], 32'h11);
    @(negedge clk);
    we = 1'b0;
    #2;
    check("seq any cleared", {31'h0, any4}, 32'd0);
    check("seq r2 stored", rd4[63:32], 32'h22);
    check("seq nb any cleared", {31'h0, any2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 The module SHALL have parameter NUM_RD, default 2, meaning read-port count (1..4).
REQ-004 The module SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write data forwarded to reads, 0 = reads see stored value only.
REQ-005 The module SHALL have parameter INIT_MODE, default 0, meaning reset contents: 0 = all zero, 1 = entry i loaded with i*10 truncated to DATA_W.
REQ-006 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-008 The module SHALL have port rd_addr, input, NUM_RD*ADDR_W bits, read addresses; port k = bits [k*ADDR_W +: ADDR_W].
REQ-009 The module SHALL have port rd_data, output, NUM_RD*DATA_W bits, read data; port k = bits [k*DATA_W +: DATA_W].
REQ-010 The module SHALL have port rd_busy, output, NUM_RD bits, 1 = addressed register has a pending reservation.
REQ-011 The module SHALL have port we, input, 1 bit, write enable.
REQ-012 The module SHALL have port waddr, input, ADDR_W bits, write address.
REQ-013 The module SHALL have port wdata, input, DATA_W bits, write data.
REQ-014 The module SHALL have port rsv_en, input, 1 bit, reserve request (instruction issue).
REQ-015 The module SHALL have port rsv_addr, input, ADDR_W bits, register to reserve.
REQ-016 The module SHALL have port any_busy, output, 1 bit, OR of all pending bits.

Function
REQ-017 Reads SHALL be combinational: rd_data[k] = mem[rd_addr[k]], zero latency.
REQ-018 Register 0 SHALL always read 0; writes and reservations to address 0 SHALL be ignored; pending[0] SHALL stay 0.
REQ-019 When we=1 and waddr!=0, mem[waddr] SHALL take wdata at the rising edge.
REQ-020 With BYPASS=1, a read port with rd_addr[k]==waddr!=0 while we=1 SHALL output wdata in the same cycle; with BYPASS=0 it SHALL output the old value until after the edge.
REQ-021 Each register SHALL have a pending bit: rsv_en=1 sets pending[rsv_addr]; we=1 clears pending[waddr]; both take effect at the edge.
REQ-022 When rsv_en and we target the same nonzero address in one cycle, the write SHALL occur and pending SHALL end set (new producer wins).
REQ-023 Reserving an already-pending register SHALL leave it pending (no counting); writing a non-pending register SHALL write data and leave pending clear.
REQ-024 rd_busy[k] SHALL equal pending[rd_addr[k]], except it SHALL be 0 when BYPASS=1, we=1 and waddr==rd_addr[k] with no same-address rsv_en in that cycle.
REQ-025 any_busy SHALL be the OR of pending[1..depth-1] as registered state (not including same-cycle requests).
REQ-026 All ports SHALL be independent; reading the same address on several ports SHALL return identical data.

Reset
REQ-027 When rst=1 at a rising edge, all pending bits SHALL clear and mem SHALL load per INIT_MODE, overriding we and rsv_en in that cycle.
REQ-028 After reset, rd_busy and any_busy SHALL be 0, and rd_data SHALL reflect the INIT_MODE contents.
REQ-029 Reset asserted mid-sequence SHALL discard all outstanding reservations; no partial state SHALL persist.

Verification
REQ-030 INIT_MODE=1, reset, then read addrs 0,1,31 -> 0, 10, 310.
REQ-031 Write 0xDEADBEEF to r5, read r5 same cycle -> BYPASS=1 gives 0xDEADBEEF; BYPASS=0 gives old value, then 0xDEADBEEF next cycle.
REQ-032 Write 0x1234 to r0, then read r0 -> 0; rsv_en on r0 -> rd_busy 0, any_busy 0.
REQ-033 Reserve r7, next cycle read r7 -> rd_busy=1, any_busy=1; write r7=0x55 -> same-cycle rd_busy=0 (BYPASS=1), after edge pending clear, data 0x55.
REQ-034 Same cycle rsv_en r9 and we r9=0xAA -> after edge data 0xAA, rd_busy for r9 = 1.
REQ-035 Reserve r3, r4, assert rst for one cycle -> any_busy=0, r3/r4 at INIT_MODE values; NUM_RD=4 with all ports on r4 -> four identical outputs.
